// File: rtl/ped_request_ctrl.sv
// Pedestrian request stage: synchronises and debounces the crossing button, then
// holds a req/ack request towards traffic_light while tracking wait time and crossings.
module ped_request_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int MAX_WAIT        = 100,
   parameter int CNT_W           = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_raw,
   input  logic             ped_ack,
   input  logic             walk_done,
   output logic             ped_req,
   output logic             ped_urgent,
   output logic             pending,
   output logic [CNT_W-1:0] wait_cnt,
   output logic [7:0]       req_count,
   output logic [1:0]       dbg_state
);

   // Handshake: ped_req is a level held from the REQUEST entry until the cycle
   // ped_ack is sampled high; walk_done is a 1-cycle pulse honoured only in SERVING.

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQUEST = 2'd1,
      S_SERVING = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic              r_sync1;
   logic              r_sync2;
   logic              r_db;
   logic [DB_W-1:0]   r_db_cnt;
   logic              r_press;
   logic              r_queued;
   logic [CNT_W-1:0]  r_wait_cnt;
   logic [7:0]        r_req_count;
   logic              w_db_flip;
   logic              w_walk_done_taken;

   // The level flips on the DEBOUNCE_CYCLES-th consecutive mismatching sample.
   assign w_db_flip = (r_sync2 != r_db) && (r_db_cnt == DB_LAST);
   assign w_walk_done_taken = (r_state == S_SERVING) && walk_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_db     <= 1'b0;
         r_db_cnt <= '0;
         r_press  <= 1'b0;
      end else begin
         r_sync1 <= btn_raw;
         r_sync2 <= r_sync1;
         r_press <= w_db_flip && !r_db;
         if (r_sync2 == r_db) begin
            r_db_cnt <= '0;
         end else if (w_db_flip) begin
            r_db     <= ~r_db;
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:    if (r_press) w_next_state = S_REQUEST;
         S_REQUEST: if (ped_ack) w_next_state = S_SERVING;
         S_SERVING: begin
            if (walk_done) begin
               w_next_state = (r_queued || r_press) ? S_REQUEST : S_IDLE;
            end
         end
         default:   w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_queued    <= 1'b0;
         r_wait_cnt  <= '0;
         r_req_count <= '0;
      end else begin
         if (w_walk_done_taken) begin
            r_queued <= 1'b0;
         end else if ((r_state == S_SERVING) && r_press) begin
            r_queued <= 1'b1;
         end
         // Counting only while staying in REQUEST clears on ack and restarts on re-entry.
         if ((r_state == S_REQUEST) && (w_next_state == S_REQUEST)) begin
            if (r_wait_cnt != WAIT_MAX) r_wait_cnt <= r_wait_cnt + 1'b1;
         end else begin
            r_wait_cnt <= '0;
         end
         if (w_walk_done_taken) r_req_count <= r_req_count + 8'd1;
      end
   end

   always_comb begin
      ped_req    = 1'b0;
      pending    = 1'b0;
      ped_urgent = 1'b0;
      case (r_state)
         S_REQUEST: begin
            ped_req    = 1'b1;
            pending    = 1'b1;
            ped_urgent = (r_wait_cnt == WAIT_MAX);
         end
         S_SERVING: pending = r_queued;
         default:   ;
      endcase
   end

   assign wait_cnt  = r_wait_cnt;
   assign req_count = r_req_count;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Directed bench for ped_request_ctrl with DEBOUNCE_CYCLES=4, MAX_WAIT=10.
module tb_ped_request_ctrl;

   localparam int CNT_W = 8;
   localparam logic [1:0] ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_SERV = 2'd2;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             btn_raw = 1'b0;
   logic             ped_ack = 1'b0;
   logic             walk_done = 1'b0;
   logic             ped_req;
   logic             ped_urgent;
   logic             pending;
   logic [CNT_W-1:0] wait_cnt;
   logic [7:0]       req_count;
   logic [1:0]       dbg_state;

   int n_checks = 0;
   int n_pass   = 0;
   int rises;
   logic prev_req;

   ped_request_ctrl #(.DEBOUNCE_CYCLES(4), .MAX_WAIT(10), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .btn_raw(btn_raw), .ped_ack(ped_ack),
      .walk_done(walk_done), .ped_req(ped_req), .ped_urgent(ped_urgent),
      .pending(pending), .wait_cnt(wait_cnt), .req_count(req_count),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req"}, ped_req, 0);
      check({tag, "_urg"}, ped_urgent, 0);
      check({tag, "_pend"}, pending, 0);
      check({tag, "_wait"}, wait_cnt, 0);
      check({tag, "_cnt"}, req_count, 0);
      check({tag, "_st"}, dbg_state, ST_IDLE);
   endtask

   initial begin
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      check_all_zero("reset");

      // 3-cycle glitch stays below the debounce threshold
      btn_raw = 1'b1;
      tick(3);
      btn_raw = 1'b0;
      tick(10);
      check("glitch_req", ped_req, 0);
      check("glitch_pend", pending, 0);
      check("glitch_st", dbg_state, ST_IDLE);

      // clean press: ped_req rises exactly on edge 7
      btn_raw = 1'b1;
      tick(6);
      check("lat_edge6_req", ped_req, 0);
      tick(1);
      check("lat_edge7_req", ped_req, 1);
      check("lat_pend", pending, 1);
      check("lat_wait0", wait_cnt, 0);
      for (int k = 1; k <= 3; k++) begin
         tick(1);
         check("wait_count", wait_cnt, k);
      end

      // saturation and urgency
      tick(6);
      check("wait9", wait_cnt, 9);
      check("urg_at9", ped_urgent, 0);
      tick(1);
      check("wait10", wait_cnt, 10);
      check("urg_at10", ped_urgent, 1);
      tick(4);
      check("wait_sat", wait_cnt, 10);
      check("urg_sat", ped_urgent, 1);

      // ack then queued press during SERVING
      ped_ack = 1'b1;
      tick(1);
      ped_ack = 1'b0;
      check("ack_req", ped_req, 0);
      check("ack_urg", ped_urgent, 0);
      check("ack_wait", wait_cnt, 0);
      check("ack_pend", pending, 0);
      check("ack_st", dbg_state, ST_SERV);
      btn_raw = 1'b0;
      tick(8);
      btn_raw = 1'b1;
      tick(6);
      check("queue_pend_before", pending, 0);
      tick(1);
      check("queue_pend", pending, 1);
      check("serv_req_low", ped_req, 0);
      walk_done = 1'b1;
      tick(1);
      walk_done = 1'b0;
      check("wd_count1", req_count, 1);
      check("wd_req_again", ped_req, 1);
      check("wd_wait_restart", wait_cnt, 0);

      // service without a queued press returns to IDLE
      ped_ack = 1'b1;
      tick(1);
      ped_ack = 1'b0;
      walk_done = 1'b1;
      tick(1);
      walk_done = 1'b0;
      check("idle_count2", req_count, 2);
      check("idle_st", dbg_state, ST_IDLE);
      check("idle_pend", pending, 0);

      // bouncing press gives exactly one request
      btn_raw = 1'b0;
      tick(8);
      rises = 0;
      prev_req = ped_req;
      for (int b = 0; b < 20; b++) begin
         btn_raw = (b < 6) ? ((b == 1 || b == 4) ? 1'b0 : 1'b1) : 1'b1;
         tick(1);
         if (ped_req && !prev_req) rises++;
         prev_req = ped_req;
      end
      check("bounce_rises", rises, 1);
      check("bounce_st", dbg_state, ST_REQ);

      // second press while in REQUEST is ignored
      btn_raw = 1'b0;
      tick(8);
      btn_raw = 1'b1;
      rises = 0;
      for (int b = 0; b < 10; b++) begin
         tick(1);
         if (!ped_req) rises++;
      end
      check("repress_req_drops", rises, 0);
      check("repress_st", dbg_state, ST_REQ);

      // simultaneous ack and walk_done: ack wins, walk_done dropped
      ped_ack = 1'b1;
      walk_done = 1'b1;
      tick(1);
      ped_ack = 1'b0;
      walk_done = 1'b0;
      check("simul_st", dbg_state, ST_SERV);
      check("simul_count", req_count, 2);
      walk_done = 1'b1;
      tick(1);
      walk_done = 1'b0;
      check("simul_count3", req_count, 3);
      check("simul_idle", dbg_state, ST_IDLE);

      // reset in REQUEST with wait_cnt=5
      btn_raw = 1'b0;
      tick(8);
      btn_raw = 1'b1;
      tick(7);
      check("pre_rst_req", ped_req, 1);
      tick(5);
      check("pre_rst_wait5", wait_cnt, 5);
      rst = 1'b1;
      tick(1);
      check_all_zero("midrst");
      tick(1);
      rst = 1'b0;
      btn_raw = 1'b0;
      tick(10);
      check("post_rst_st", dbg_state, ST_IDLE);
      check("post_rst_req", ped_req, 0);

      // button held through reset re-debounces from the release edge
      btn_raw = 1'b1;
      tick(8);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(6);
      check("held_rst_edge6", ped_req, 0);
      tick(1);
      check("held_rst_edge7", ped_req, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
